// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared uart_tx input.
// master = arbiter (owns the uart_tx-facing port), slave = requesters plus uart_tx.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W_OUT = 24
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            s_valid;
    logic [N_REQ-1:0][W_OUT-1:0] s_data;
    logic [N_REQ-1:0]            s_ready;
    logic                        m_valid;
    logic [W_OUT-1:0]            m_data;
    logic                        m_ready;
    logic [SRC_W-1:0]            m_src;
    logic                        busy;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_src, busy
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_src, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with a burst limit sharing one uart_tx between N_REQ requesters.
// One packet is buffered at a time; priority rotates after MAX_BURST grants or a lost claim.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 24,
    parameter int MAX_BURST     = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W:0]   N_WIDE     = (SRC_W + 1)'(N_REQ);

    if (N_REQ < 2) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be at least 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("uart_tx_arbiter: MAX_BURST must be at least 1");
    end
    if ((W_OUT % BITS_PER_WORD) != 0) begin : g_bad_width
        $error("uart_tx_arbiter: W_OUT must be a multiple of BITS_PER_WORD");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [SRC_W-1:0] ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [W_OUT-1:0] buf_data;
    logic [SRC_W-1:0] src;
    logic             m_valid_q;
    logic             busy_q;

    logic [SRC_W-1:0] winner;
    logic             any_req;
    logic [SRC_W:0]   cand;
    logic [SRC_W-1:0] ptr_after;

    // Scan ptr, ptr+1, ... with an explicit wrap so N_REQ need not be a power of 2.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner  = ptr;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (SRC_W + 1)'(k);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (!any_req && bus.s_valid[cand[SRC_W-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        bus.s_ready = '0;
        if (state == IDLE && any_req) begin
            bus.s_ready[winner] = 1'b1;
        end
    end

    assign ptr_after   = (src == LAST_IDX) ? '0 : src + 1'b1;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = buf_data;
    assign bus.m_src   = src;
    assign bus.busy    = busy_q;

    always_ff @(posedge clk) begin
        // NOTE: the payload buffer is a plain register, so it is reset with the rest to keep m_data at 0.
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            buf_data  <= '0;
            src       <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (any_req) begin
                        buf_data  <= bus.s_data[winner];
                        src       <= winner;
                        state     <= SEND;
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        // A different winner starts a fresh burst.
                        if (winner != ptr) begin
                            burst_cnt <= '0;
                        end
                    end
                end
                SEND: begin
                    if (bus.m_ready) begin
                        state     <= IDLE;
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (burst_cnt == BURST_LAST) begin
                            ptr       <= ptr_after;
                            burst_cnt <= '0;
                        end else begin
                            ptr       <= src;
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer between `N_REQ` independent requesters. It accepts one `W_OUT`-bit word group from the winning requester, holds it in a single-entry buffer, and presents it on a valid/ready port wired directly to the `uart_tx` input (`s_valid`, `s_data`, `s_ready`). A configurable burst limit lets one requester send up to `MAX_BURST` consecutive packets before priority rotates.

## Interface
- `N_REQ`, 4: number of requesters, ≥2, need not be a power of 2
- `BITS_PER_WORD`, 8: UART word width; must match `uart_tx`
- `W_OUT`, 24: packet payload width, a multiple of `BITS_PER_WORD`; must match `uart_tx`
- `MAX_BURST`, 2: maximum consecutive packets granted to one requester, ≥1 (1 = pure round-robin)

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `s_valid` in N_REQ: per-requester request; bit i = requester i
- `s_data` in N_REQ×W_OUT: per-requester payload, packed `[N_REQ-1:0][W_OUT-1:0]`
- `s_ready` out N_REQ: one-hot accept strobe; at most one bit high
- `m_valid` out 1: buffered packet valid; to `uart_tx.s_valid`
- `m_data` out W_OUT: buffered payload; to `uart_tx.s_data`
- `m_ready` in 1: from `uart_tx.s_ready`
- `m_src` out $clog2(N_REQ): index of the requester owning `m_data`
- `busy` out 1: high while a packet is buffered (state SEND)

## Operation
- Registers: `state` {IDLE, SEND}, `ptr` (priority index), `burst_cnt` ($clog2(MAX_BURST)+1 bits), `buf_data`, `src`.
- Winner (combinational): the first i with `s_valid[i]=1`, scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1. Wrap is modulo N_REQ, not modulo a power of 2.
- IDLE:
  - `s_ready` = one-hot(winner) if any `s_valid`, else 0. `m_valid`=0.
  - On an edge with any `s_valid`: `buf_data`←`s_data[winner]`, `src`←winner, state→SEND.
  - At the same edge, if winner≠ptr, `burst_cnt`←0.
- SEND:
  - `s_ready`=0. `m_valid`=1, `m_data`=`buf_data`, `m_src`=`src`, all stable until the handshake.
  - On an edge with `m_ready`=1: state→IDLE.
  - If `burst_cnt`==MAX_BURST-1: `ptr`←(src+1) mod N_REQ, `burst_cnt`←0.
  - Otherwise: `ptr`←src, `burst_cnt`←`burst_cnt`+1.
- Requesters may drop or change `s_valid`/`s_data` at any time before their `s_ready` edge. A dropped request is simply not granted, with no penalty.
- A requester must not count a transfer except on an edge where its `s_valid` and `s_ready` bits are both high.
- Payload is forwarded bit-exact; no reordering, duplication or loss.

## Timing
- Reset values: state=IDLE, `ptr`=0, `burst_cnt`=0, `buf_data`=0, `src`=0. Outputs after reset: `s_ready`=0 (absent requests), `m_valid`=0, `m_data`=0, `m_src`=0, `busy`=0.
- Reset during SEND discards the buffered packet: `m_valid`=0 in the cycle after the reset edge. `uart_tx` is reset by its own reset and is not affected by this block.
- Request latency: request sampled at edge k → `m_valid`=1 from edge k to the handshake edge. Minimum is 1 cycle from acceptance to `m_valid`.
- `m_ready` is ignored in IDLE, and `s_valid` is ignored in SEND.
- After a handshake at edge h, IDLE during cycle h→h+1; the next acceptance is at edge h+1 at the earliest. This gives 2 cycles minimum per packet, and `uart_tx` serialization dominates throughput.
- `m_ready` high at the same edge that `m_valid` first rises is legal and completes the transfer at the next edge with `m_ready`=1.
- `s_ready` is combinational from `s_valid` and `ptr`. There is no combinational path from `m_ready` to any output.

## Test plan
Bench: DUT driving `uart_tx` (CLOCKS_PER_PULSE=4, W_OUT=16, BITS_PER_WORD=8), plus a UART monitor decoding `tx`. Requester payload is `{i, seq}`.

1. Single requester: requester 2 sends 0xA5C3 once → `s_ready`=4'b0100 for 1 cycle; `m_valid` next cycle with `m_data`=0xA5C3, `m_src`=2. Monitor decodes 0xA5C3. `busy` falls after the handshake.
2. All four requesting continuously, MAX_BURST=1 → grant order 0,1,2,3,0,1,… across 12 packets. No requester gets two consecutive grants. Every decoded packet matches its `m_src`.
3. All four requesting, MAX_BURST=2 → order 0,0,1,1,2,2,3,3,0,0. `burst_cnt` returns to 0 at each rotation.
4. Burst broken early, MAX_BURST=3: requester 1 sends 1 packet then drops `s_valid`; requester 3 is requesting → next grant is 3 with `burst_cnt`=0. Repeat with N_REQ=3: wrap 2→0 is correct.
5. Reset mid-SEND: assert `rst` for 1 cycle while `m_valid`=1 and `m_ready`=0 → `m_valid`=0, `m_src`=0, `ptr`=0 the next cycle. With all requesters then valid, the first grant is 0.
6. Request withdrawn: requester 0 pulses `s_valid` in a cycle while SEND → never granted, no `s_ready[0]`. Randomized mix of 200 packets → scoreboard shows zero loss or duplication, and every requester is served within N_REQ×MAX_BURST grants of requesting.
